// File: rtl/gol_vga_pkg.sv
// rtl/gol_vga_pkg.sv - shared VGA timing defaults, pixel types and cell-lane select
package gol_vga_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_HT        = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_VT        = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_CELL_LOG2 = 4;
  localparam int DEF_COLS      = DEF_H_ACTIVE >> DEF_CELL_LOG2;
  localparam int DEF_ROWS      = DEF_V_ACTIVE >> DEF_CELL_LOG2;

  localparam logic [31:0] DEF_FB0_BASE = 32'h200;
  localparam logic [31:0] DEF_FB1_BASE = DEF_FB0_BASE + 32'(DEF_COLS * DEF_ROWS / 4);

  // Counter width covers totals up to 1023 clocks/lines; cell index up to 2047
  localparam int CNT_W = 10;
  localparam int IDX_W = 11;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [11:0]      rgb_t;

  localparam rgb_t DEF_ALIVE_RGB = 12'hFFF;
  localparam rgb_t DEF_DEAD_RGB  = 12'h000;

  // Control bits that travel alongside the frame-buffer read
  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [1:0] lane;
  } pix_ctl_t;

  // Byte lane k occupies bits 8k+7:8k, matching sb/lbu addressing
  function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/gol_fb_scanout_if.sv
// rtl/gol_fb_scanout_if.sv - read-only frame-buffer port between scan-out and RAM
interface gol_fb_scanout_if;
  logic        fb_re;
  logic [31:0] fb_adr;
  logic [31:0] fb_rdata;

  modport master (output fb_re, output fb_adr, input fb_rdata);
  modport slave  (input fb_re, input fb_adr, output fb_rdata);
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel/line counters with active, sync and end-of-frame strobes
module vga_timing
  import gol_vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic reset,
  output cnt_t hcnt_o,
  output cnt_t vcnt_o,
  output logic active_o,
  output logic hsync_on_o,
  output logic vsync_on_o,
  output logic eof_o
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  cnt_t hcnt_q, vcnt_q;
  logic run_q;

  // First edge after reset arms run_q so (0,0) is a full, live pixel; then count raster order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      run_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        if (hcnt_q == cnt_t'(HT - 1)) begin
          hcnt_q <= '0;
          vcnt_q <= (vcnt_q == cnt_t'(VT - 1)) ? '0 : vcnt_q + 1'b1;
        end else begin
          hcnt_q <= hcnt_q + 1'b1;
        end
      end
    end
  end

  assign hcnt_o     = hcnt_q;
  assign vcnt_o     = vcnt_q;
  assign active_o   = run_q && (hcnt_q < cnt_t'(H_ACTIVE)) && (vcnt_q < cnt_t'(V_ACTIVE));
  assign hsync_on_o = (hcnt_q >= cnt_t'(H_ACTIVE + H_FP)) &&
                      (hcnt_q <  cnt_t'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_on_o = (vcnt_q >= cnt_t'(V_ACTIVE + V_FP)) &&
                      (vcnt_q <  cnt_t'(V_ACTIVE + V_FP + V_SYNC));
  assign eof_o      = run_q && (hcnt_q == cnt_t'(HT - 1)) && (vcnt_q == cnt_t'(VT - 1));

endmodule

// File: rtl/gol_fb_scanout.sv
// rtl/gol_fb_scanout.sv - Game of Life frame-buffer scan-out with end-of-frame buffer swap
module gol_fb_scanout
  import gol_vga_pkg::*;
#(
  parameter int          H_ACTIVE  = DEF_H_ACTIVE,
  parameter int          H_FP      = DEF_H_FP,
  parameter int          H_SYNC    = DEF_H_SYNC,
  parameter int          H_BP      = DEF_H_BP,
  parameter int          V_ACTIVE  = DEF_V_ACTIVE,
  parameter int          V_FP      = DEF_V_FP,
  parameter int          V_SYNC    = DEF_V_SYNC,
  parameter int          V_BP      = DEF_V_BP,
  parameter int          CELL_LOG2 = DEF_CELL_LOG2,
  parameter logic [31:0] FB0_BASE  = DEF_FB0_BASE,
  parameter logic [31:0] FB1_BASE  = FB0_BASE +
                                     32'(((H_ACTIVE >> CELL_LOG2) * (V_ACTIVE >> CELL_LOG2)) / 4),
  parameter rgb_t        ALIVE_RGB = DEF_ALIVE_RGB,
  parameter rgb_t        DEAD_RGB  = DEF_DEAD_RGB
) (
  input  logic             clk,
  input  logic             reset,
  gol_fb_scanout_if.master fb,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             disp_buf,
  output rgb_t             rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_start
);
  localparam int COLS = H_ACTIVE >> CELL_LOG2;

  cnt_t     hcnt, vcnt;
  logic     active, hs_on, vs_on, eof;
  idx_t     row_base_q, cell_idx;
  logic     line_end;
  logic     pend_q, disp_buf_q, swap_ack_q;
  pix_ctl_t ctl_d, ctl1_q;
  rgb_t     rgb_d, rgb_q;
  logic     hsync_q, vsync_q, video_on_q, frame_start_q;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .hcnt_o     (hcnt),
    .vcnt_o     (vcnt),
    .active_o   (active),
    .hsync_on_o (hs_on),
    .vsync_on_o (vs_on),
    .eof_o      (eof)
  );

  // Cell index is built by accumulation so no multiplier sits in the address path
  assign line_end = active && (hcnt == cnt_t'(H_ACTIVE - 1));
  assign cell_idx = row_base_q + idx_t'(hcnt >> CELL_LOG2);
  assign fb.fb_re  = active;
  assign fb.fb_adr = (disp_buf_q ? FB1_BASE : FB0_BASE) + 32'(cell_idx[IDX_W-1:2]);

  assign ctl_d = '{act:  active,
                   hs:   hs_on,
                   vs:   vs_on,
                   fs:   active && (hcnt == '0) && (vcnt == '0),
                   lane: cell_idx[1:0]};

  assign rgb_d = !ctl1_q.act ? rgb_t'(0) :
                 (lane_sel(fb.fb_rdata, ctl1_q.lane) != 8'h00) ? ALIVE_RGB : DEAD_RGB;

  // Step the row base past each finished cell row; restart it at the frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_base_q <= '0;
    end else if (eof) begin
      row_base_q <= '0;
    end else if (line_end && (&vcnt[CELL_LOG2-1:0])) begin
      row_base_q <= row_base_q + idx_t'(COLS);
    end
  end

  // Latch swap requests and apply one at the end of frame; a request on that cycle waits a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= 1'b0;
      disp_buf_q <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      swap_ack_q <= 1'b0;
      if (eof && pend_q) begin
        disp_buf_q <= ~disp_buf_q;
        pend_q     <= swap_req;
        swap_ack_q <= 1'b1;
      end else if (swap_req) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Carry control across the RAM read cycle, then register all pixel outputs together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl1_q        <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      ctl1_q        <= ctl_d;
      rgb_q         <= rgb_d;
      hsync_q       <= ~ctl1_q.hs;
      vsync_q       <= ~ctl1_q.vs;
      video_on_q    <= ctl1_q.act;
      frame_start_q <= ctl1_q.fs;
    end
  end

  assign swap_ack    = swap_ack_q;
  assign disp_buf    = disp_buf_q;
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule
